// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
// Header length and checksum width are fixed by the stream format.
package boot_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } bootState_e;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;
  localparam int LEN_W     = 8 * HDR_BYTES;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// The master side is the byte source and memory; the slave side is the loader.
interface boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/byte_packer.sv
// Assembles MSB-first bytes into a 32-bit word.
// wordNext already includes byteIn so the caller can capture the full word on the 4th transfer.
module byte_packer (
  input  logic        clk,
  input  logic        rstN,
  input  logic        clr,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] wordNext,
  output logic        wordFull
);

  logic [31:0] word;
  logic [1:0]  byteCnt;

  assign wordNext = {word[23:0], byteIn};
  assign wordFull = shiftEn && (byteCnt == 2'd3);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      word    <= '0;
      byteCnt <= '0;
    end else if (clr) begin
      word    <= '0;
      byteCnt <= '0;
    end else if (shiftEn) begin
      word    <= wordNext;
      byteCnt <= byteCnt + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed, XOR-checksummed program image and writes it to CPU memory,
// holding the CPU in reset until the image is verified.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  boot_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

  bootState_e        state, stateNext;
  logic [7:0]        lenHi;
  logic [LEN_W-1:0]  numWords;
  logic [LEN_W-1:0]  wordIdx;
  logic [CSUM_W-1:0] xorAcc;
  logic [31:0]       memAddr;
  logic [31:0]       memWdata;

  logic              xfer;
  logic              rearm;
  logic              lastWord;
  logic [LEN_W-1:0]  hdrLen;
  logic [31:0]       wordNext;
  logic              wordFull;

  assign bus.rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA)   || (state == CHECK);
  assign xfer     = bus.rx_valid && bus.rx_ready;
  assign rearm    = start && ((state == DONE) || (state == ERROR));
  assign hdrLen   = {lenHi, bus.rx_data};
  assign lastWord = ({1'b0, wordIdx} + (LEN_W+1)'(1)) >= {1'b0, numWords};

  assign bus.mem_wr    = (state == WRITE);
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign cpu_reset     = (state != DONE);
  assign done          = (state == DONE);
  assign err           = (state == ERROR);

  byte_packer uPacker (
    .clk      (clk),
    .rstN     (reset),
    .clr      (rearm),
    .shiftEn  ((state == DATA) && xfer),
    .byteIn   (bus.rx_data),
    .wordNext (wordNext),
    .wordFull (wordFull)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LEN_HI;
      lenHi    <= '0;
      numWords <= '0;
      wordIdx  <= '0;
      xorAcc   <= '0;
      memAddr  <= BASE_ADDR;
      memWdata <= '0;
    end else begin
      state <= stateNext;
      if ((state == LEN_HI) && xfer) lenHi <= bus.rx_data;
      if ((state == LEN_LO) && xfer) numWords <= hdrLen;
      if ((state == DATA) && xfer) xorAcc <= xorAcc ^ bus.rx_data;
      // Address and data are latched on the 4th byte so they are stable throughout WRITE.
      if ((state == DATA) && wordFull) begin
        memAddr  <= BASE_ADDR + 32'({wordIdx, 2'b00});
        memWdata <= wordNext;
      end
      if (state == WRITE) wordIdx <= wordIdx + LEN_W'(1);
      if (rearm) begin
        wordIdx <= '0;
        xorAcc  <= '0;
      end
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      LEN_HI: if (xfer) stateNext = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (hdrLen == '0)        stateNext = CHECK;
          else if (hdrLen > MAX_N) stateNext = ERROR;
          else                     stateNext = DATA;
        end
      end
      DATA:   if (wordFull) stateNext = WRITE;
      WRITE:  stateNext = lastWord ? CHECK : DATA;
      CHECK:  if (xfer) stateNext = (bus.rx_data == xorAcc) ? DONE : ERROR;
      DONE:   if (start) stateNext = LEN_HI;
      ERROR:  if (start) stateNext = LEN_HI;
      default: stateNext = LEN_HI;
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of complete streams plus hand sequences
// for header overflow, the 64-word limit, write latency and mid-load reset.
module tb_boot_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, done, err;

  boot_loader_if bus();

  boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  logic [31:0] wrA [0:255];
  logic [31:0] wrD [0:255];
  int wrTot = 0;

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1 && wrTot < 256) begin
      wrA[wrTot] = bus.mem_addr;
      wrD[wrTot] = bus.mem_wdata;
      wrTot++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge that took the byte.
  task automatic sendByte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk); #1; end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      nCmp++; nErr++;
      $display("FAIL send_timeout: rx_ready never rose for byte %h", b);
    end else begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [95:0] s;
    int          len;
    bit          stall;
    int          nWr;
    logic [31:0] a0, d0, a1, d1;
    bit          expDone;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    int base;
    vec_t v;
    logic [7:0] b;

    vecs[0] = '{96'h0001DEADBEEF22, 7, 1'b0, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1};
    vecs[1] = '{96'h0002000000010000000203, 11, 1'b0, 2, 32'h0, 32'h1, 32'h4, 32'h2, 1'b1};
    vecs[2] = '{96'h00011122334400, 7, 1'b0, 1, 32'h0, 32'h11223344, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{96'h000000, 3, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[4] = '{96'h0002000000010000000203, 11, 1'b1, 2, 32'h0, 32'h1, 32'h4, 32'h2, 1'b1};
    vecs[5] = '{96'h000005, 3, 1'b1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};

    reset = 1'b0; start = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    #3;
    chk("rst_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven streams; the leading start pulse rearms from DONE/ERROR and is ignored in LEN_HI.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      pulseStart();
      base = wrTot;
      for (int j = 0; j < v.len; j++) begin
        b = v.s[8*(v.len-1-j) +: 8];
        sendByte(b, v.stall);
      end
      chk($sformatf("v%0d_done", i), 32'(done), 32'(v.expDone));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(!v.expDone));
      chk($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'(!v.expDone));
      chk($sformatf("v%0d_ready", i), 32'(bus.rx_ready), 32'd0);
      chk($sformatf("v%0d_nwr", i), 32'(wrTot - base), 32'(v.nWr));
      if (v.nWr >= 1) begin
        chk($sformatf("v%0d_a0", i), wrA[base], v.a0);
        chk($sformatf("v%0d_d0", i), wrD[base], v.d0);
      end
      if (v.nWr >= 2) begin
        chk($sformatf("v%0d_a1", i), wrA[base+1], v.a1);
        chk($sformatf("v%0d_d1", i), wrD[base+1], v.d1);
        chk($sformatf("v%0d_wdata_hold", i), bus.mem_wdata, v.d1);
      end
    end

    // Oversized header: ERROR right after the second byte, nothing written, start clears it.
    pulseStart();
    base = wrTot;
    sendByte(8'h00, 1'b0);
    sendByte(8'h41, 1'b0);
    chk("n65_err", 32'(err), 32'd1);
    chk("n65_cpu_reset", 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
    chk("n65_nwr", 32'(wrTot - base), 32'd0);
    pulseStart();
    chk("n65_rearm_err", 32'(err), 32'd0);
    chk("n65_rearm_ready", 32'(bus.rx_ready), 32'd1);

    // MAX_WORDS boundary with word i = i; XOR of 0..63 is 0.
    base = wrTot;
    sendByte(8'h00, 1'b0);
    sendByte(8'h40, 1'b0);
    for (int w = 0; w < 64; w++) begin
      sendByte(8'h00, 1'b0);
      sendByte(8'h00, 1'b0);
      sendByte(8'h00, 1'b0);
      sendByte(8'(w), 1'b0);
      if (w == 0) begin
        chk("lat_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("lat_ready_low", 32'(bus.rx_ready), 32'd0);
        chk("lat_addr", bus.mem_addr, 32'h0);
      end
    end
    sendByte(8'h00, 1'b0);
    chk("n64_done", 32'(done), 32'd1);
    chk("n64_nwr", 32'(wrTot - base), 32'd64);
    chk("n64_last_addr", wrA[base+63], 32'h0000_00FC);
    chk("n64_last_data", wrD[base+63], 32'h0000_003F);

    // Reset while the 3rd byte of word 1 is on the bus.
    pulseStart();
    sendByte(8'h00, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'h00, 1'b0); sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0); sendByte(8'h01, 1'b0);
    sendByte(8'hAA, 1'b0); sendByte(8'hBB, 1'b0);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hCC;
    #2 reset = 1'b0;
    #1;
    bus.rx_valid = 1'b0;
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_wdata", bus.mem_wdata, 32'h0);
    chk("mid_rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("mid_rst_ready", 32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    base = wrTot;
    sendByte(8'h00, 1'b0); sendByte(8'h01, 1'b0);
    sendByte(8'hCA, 1'b0); sendByte(8'hFE, 1'b0);
    sendByte(8'hBA, 1'b0); sendByte(8'hBE, 1'b0);
    sendByte(8'h30, 1'b0);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_nwr", 32'(wrTot - base), 32'd1);
    chk("post_rst_addr", wrA[base], 32'h0);
    chk("post_rst_data", wrD[base], 32'hCAFEBABE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
